// File: rtl/clock_divider_meter.sv
// Measures the half-period of a slow square wave and reports it as the
// divider number (half-period in clk cycles minus 1) that would produce it.
module clock_divider_meter #(
  parameter int WIDTH          = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             enable,
  output logic [WIDTH-1:0] meas_num,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sclk_d;
  logic                   sclk_edge;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             cnt_hit;
  logic             res_fire;
  logic [WIDTH-1:0] res_val;
  logic             res_load;
  logic [WIDTH-1:0] prev_num;
  logic             prev_vld;

  // NOTE: flops take <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sclk_in};
      sclk_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_edge = sync_q[SYNC_STAGES-1] ^ sclk_d;

  // Edge wins over a stall that would be declared in the same cycle.
  assign cnt_hit  = enable && (state != ST_IDLE) && !sclk_edge && (cnt == CNT_LAST);
  assign res_load = res_fire && (!meas_valid || meas_ready);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    res_fire  = 1'b0;
    res_val   = cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: if (sclk_edge) state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (sclk_edge) begin
            res_fire = 1'b1;
          end else if (cnt_hit) begin
            state_nxt = ST_ACQUIRE;
            res_fire  = 1'b1;
            res_val   = '0;
          end
        end
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE || state_nxt == ST_IDLE || sclk_edge || cnt_hit)
        cnt <= '0;
      else
        cnt <= cnt + WIDTH'(1);
      if (state_nxt == ST_IDLE || sclk_edge)
        timeout <= 1'b0;
      else if (cnt_hit)
        timeout <= 1'b1;
    end
  end

  // Result register with drop-on-full; history follows loaded results only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_num   <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      locked     <= 1'b0;
      prev_num   <= '0;
      prev_vld   <= 1'b0;
    end else begin
      overrun <= res_fire && !res_load;
      if (res_load) begin
        meas_num   <= res_val;
        meas_valid <= 1'b1;
      end else if (meas_ready) begin
        meas_valid <= 1'b0;
      end
      if (state_nxt == ST_IDLE) begin
        locked   <= 1'b0;
        prev_vld <= 1'b0;
      end else if (cnt_hit) begin
        locked <= 1'b0;
        if (res_load) begin
          prev_num <= '0;
          prev_vld <= 1'b1;
        end
      end else if (res_load) begin
        locked   <= prev_vld && (res_val == prev_num);
        prev_num <= res_val;
        prev_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_meter.sv
// Scoreboarded bench for clock_divider_meter: a clk-synchronous square wave is
// generated, the expected divider numbers are queued and matched on handshake.
module tb_clock_divider_meter;

  localparam int W = 20;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk_in;
  logic         enable;
  logic         meas_ready;
  logic [W-1:0] meas_num;
  logic         meas_valid;
  logic         locked;
  logic         timeout;
  logic         overrun;

  clock_divider_meter #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .enable(enable),
    .meas_num(meas_num), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .locked(locked), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] num;
    logic         lk;
    logic         chk_lk;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           since = 0;
  bit           acq = 0;
  bit           hist_v = 0;
  logic [W-1:0] prev = '0;
  int           cyc = 0;
  int           ovr_cyc[$];

  // Monitor: a handshake at the next rising edge consumes the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n === 1'b1 && overrun === 1'b1) ovr_cyc.push_back(cyc);
    if (rst_n === 1'b1 && meas_valid === 1'b1 && meas_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow got num=%0d exp=<none>", meas_num);
      end else begin
        e = sb.pop_front();
        if (meas_num !== e.num) begin
          bad++;
          $display("FAIL sb_num got=%0d exp=%0d cyc=%0d", meas_num, e.num, cyc);
        end
        if (e.chk_lk) begin
          total++;
          if (locked !== e.lk) begin
            bad++;
            $display("FAIL sb_locked got=%0b exp=%0b cyc=%0d", locked, e.lk, cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  // Toggle the wave; once acquired, the closed interval yields since-1.
  task automatic flip(input bit push_en);
    logic [W-1:0] r;
    exp_t         e;
    sclk_in = ~sclk_in;
    if (acq && push_en) begin
      r        = W'(since - 1);
      e.num    = r;
      e.lk     = hist_v && (r == prev);
      e.chk_lk = 1'b1;
      sb.push_back(e);
      prev   = r;
      hist_v = 1'b1;
    end
    acq   = 1'b1;
    since = 0;
  endtask

  task automatic wave(input int h, input int n, input bit push_en);
    repeat (n) begin
      repeat (h) tick();
      flip(push_en);
    end
  endtask

  task automatic model_idle();
    acq    = 1'b0;
    hist_v = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] num, input logic lk, input logic chk_lk);
    exp_t e;
    e.num    = num;
    e.lk     = lk;
    e.chk_lk = chk_lk;
    sb.push_back(e);
  endtask

  task automatic idle_gap(input string name);
    repeat (8) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d pending exp=0", name, sb.size());
      sb.delete();
    end
    enable = 1'b0;
    repeat (2) tick();
    model_idle();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk_in = 1'b0; enable = 1'b0; meas_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (meas_num !== '0)    begin bad++; $display("FAIL reset_num got=%0d exp=0", meas_num); end
    if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", meas_valid); end
    if (locked !== 1'b0)    begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    if (timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    rst_n = 1'b1; enable = 1'b1;
    model_idle();
    tick();
  endtask

  task automatic test_loopback();
    wave(5, 6, 1'b1);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL loop_timeout got=%0b exp=0", timeout); end
    idle_gap("loop");
  endtask

  task automatic test_timeout();
    wave(5, 3, 1'b1);
    repeat (T + 2) tick();
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%0b exp=0", timeout); end
    tick();
    push_exp('0, 1'b0, 1'b1);
    prev = '0; hist_v = 1'b1; acq = 1'b0;
    total += 4;
    if (timeout !== 1'b1)    begin bad++; $display("FAIL to_set got=%0b exp=1", timeout); end
    if (meas_valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%0b exp=1", meas_valid); end
    if (meas_num !== '0)     begin bad++; $display("FAIL to_num got=%0d exp=0", meas_num); end
    if (locked !== 1'b0)     begin bad++; $display("FAIL to_locked got=%0b exp=0", locked); end
    repeat (3) tick();
    flip(1'b1);
    repeat (2) tick();
    total++;
    if (timeout !== 1'b1) begin bad++; $display("FAIL to_hold got=%0b exp=1", timeout); end
    tick();
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b exp=0", timeout); end
    idle_gap("timeout");
  endtask

  task automatic test_overrun();
    meas_ready = 1'b0;
    ovr_cyc.delete();
    wave(5, 4, 1'b0);
    repeat (4) tick();
    total++;
    if (ovr_cyc.size() != 2) begin
      bad++;
      $display("FAIL ovr_count got=%0d exp=2", ovr_cyc.size());
    end else begin
      total++;
      if (ovr_cyc[1] - ovr_cyc[0] != 5) begin
        bad++;
        $display("FAIL ovr_spacing got=%0d exp=5", ovr_cyc[1] - ovr_cyc[0]);
      end
    end
    total += 2;
    if (meas_num !== W'(4))  begin bad++; $display("FAIL ovr_hold_num got=%0d exp=4", meas_num); end
    if (meas_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold_valid got=%0b exp=1", meas_valid); end
    push_exp(W'(4), 1'b0, 1'b0);
    meas_ready = 1'b1;
    tick();
    total++;
    if (meas_valid !== 1'b0) begin bad++; $display("FAIL ovr_release got=%0b exp=0", meas_valid); end
    idle_gap("overrun");
  endtask

  task automatic test_switch();
    wave(5, 3, 1'b1);
    wave(10, 3, 1'b1);
    idle_gap("switch");
  endtask

  task automatic test_fast();
    wave(1, 8, 1'b1);
    total += 2;
    if (timeout !== 1'b0) begin bad++; $display("FAIL fast_timeout got=%0b exp=0", timeout); end
    if (locked !== 1'b1)  begin bad++; $display("FAIL fast_locked got=%0b exp=1", locked); end
    idle_gap("fast");
  endtask

  task automatic test_reset_mid();
    wave(5, 3, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    sclk_in = 1'b0;
    #1;
    total += 3;
    if (meas_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", meas_valid); end
    if (meas_num !== '0)     begin bad++; $display("FAIL rmid_num got=%0d exp=0", meas_num); end
    if (locked !== 1'b0)     begin bad++; $display("FAIL rmid_locked got=%0b exp=0", locked); end
    repeat (2) tick();
    rst_n = 1'b1;
    model_idle();
    repeat (3) tick();
    wave(5, 2, 1'b1);
    idle_gap("rmid");
  endtask

  task automatic test_disable();
    wave(5, 3, 1'b1);
    repeat (4) tick();
    meas_ready = 1'b0;
    tick();
    flip(1'b0);
    repeat (4) tick();
    total += 2;
    if (locked !== 1'b1)     begin bad++; $display("FAIL dis_pre_locked got=%0b exp=1", locked); end
    if (meas_valid !== 1'b1) begin bad++; $display("FAIL dis_pre_valid got=%0b exp=1", meas_valid); end
    enable = 1'b0;
    tick();
    total += 3;
    if (locked !== 1'b0)     begin bad++; $display("FAIL dis_locked got=%0b exp=0", locked); end
    if (meas_valid !== 1'b1) begin bad++; $display("FAIL dis_valid got=%0b exp=1", meas_valid); end
    if (meas_num !== W'(4))  begin bad++; $display("FAIL dis_num got=%0d exp=4", meas_num); end
    push_exp(W'(4), 1'b0, 1'b1);
    meas_ready = 1'b1;
    tick();
    total++;
    if (meas_valid !== 1'b0) begin bad++; $display("FAIL dis_accept got=%0b exp=0", meas_valid); end
    model_idle();
    enable = 1'b1;
    tick();
    idle_gap("disable");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_timeout();
    test_overrun();
    test_switch();
    test_fast();
    test_reset_mid();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
